accumulator: RTL

- Running-sum stage directly downstream of `Adder`.
- Accepts a stream of `BITS`-wide operands over a valid/ready handshake and drives them into an internal `Adder` instance as addend, with the stored total as augend.
- Folds each sum back into the total register, tracks a sticky carry-out and a term count.
- Presents the finished result on a second valid/ready handshake when the operand marked last has been absorbed.

---
 rtl/accumulator.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/accumulator.sv
// accumulator: running-sum stage built around an Adder instance.
//
// Operands arrive on a valid/ready handshake and are added to the stored
// total. Each accepted sum is folded back into the total. The stage also keeps
// a sticky carry-out and a saturating count of accepted terms. When the operand
// flagged last has been absorbed, the result is held on a second valid/ready
// handshake until the consumer takes it.
//
// Optional feature macro: ACCUMULATOR_SATURATE_EN
//   defined   - an accepted addition that carries out clamps total to all-ones
//   undefined - total wraps modulo 2^BITS (default build)
//
// Parameters:
//   BITS        operand / total width (passed to Adder)
//   COUNT_BITS  width of the accepted-term counter
//
// Ports:
//   i_clock    clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_clear    synchronous clear of total/carry/count, back to accumulate
//   i_valid    operand valid
//   o_ready    operand ready (state-decoded)
//   i_operand  unsigned operand
//   i_last     final operand of a sequence, sampled on accept
//   o_valid    result valid (state-decoded)
//   i_ready    result consumer ready
//   o_total    running or final total
//   o_carry    sticky adder carry-out
//   o_count    number of operands accepted in the current sequence
//
// The file also holds the Adder leaf so the stage is self-contained.

module Adder #(
    parameter int unsigned BITS = 4
) (
    input  logic [BITS-1:0] i_augend,
    input  logic [BITS-1:0] i_addend,
    output logic [BITS-1:0] o_sum,
    output logic            o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_augend} + {1'b0, i_addend};

endmodule

module accumulator #(
    parameter int unsigned BITS       = 4,
    parameter int unsigned COUNT_BITS = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [BITS-1:0]       i_operand,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [BITS-1:0]       o_total,
    output logic                  o_carry,
    output logic [COUNT_BITS-1:0] o_count
);

    typedef enum logic {
        StAccumulate = 1'b0,
        StHold       = 1'b1
    } state_e;

    localparam logic [COUNT_BITS-1:0] CountMax = {COUNT_BITS{1'b1}};

    state_e                state_q, state_d;
    logic [BITS-1:0]       total_q, total_d;
    logic                  carry_q, carry_d;
    logic [COUNT_BITS-1:0] count_q, count_d;

    logic [BITS-1:0] sum;
    logic            sum_carry;
    logic            accept;

    Adder #(
        .BITS (BITS)
    ) u_adder (
        .i_augend (total_q),
        .i_addend (i_operand),
        .o_sum    (sum),
        .o_carry  (sum_carry)
    );

    // Handshake outputs come from the state register only.
    assign o_ready = (state_q == StAccumulate);
    assign o_valid = (state_q == StHold);
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        carry_d = carry_q;
        count_d = count_q;

        if (i_clear) begin
            // Clear overrides any concurrent operand or result handshake.
            state_d = StAccumulate;
            total_d = '0;
            carry_d = 1'b0;
            count_d = '0;
        end else begin
            unique case (state_q)
                StAccumulate: begin
                    if (accept) begin
`ifdef ACCUMULATOR_SATURATE_EN
                        // Once clamped, later adds of nonzero carry out again,
                        // and adds of zero leave all-ones, so the clamp holds.
                        total_d = sum_carry ? {BITS{1'b1}} : sum;
`else
                        total_d = sum;
`endif
                        carry_d = carry_q | sum_carry;
                        count_d = (count_q == CountMax) ? count_q : count_q + 1'b1;
                        if (i_last) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (i_ready) begin
                        state_d = StAccumulate;
                        total_d = '0;
                        carry_d = 1'b0;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = StAccumulate;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StAccumulate;
            total_q <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    assign o_total = total_q;
    assign o_carry = carry_q;
    assign o_count = count_q;

endmodule
